uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter between two byte sources.
// Optional watchdog built when TXARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       req_a,
  input  logic [7:0] data_a,
  input  logic       req_b,
  input  logic [7:0] data_b,
  input  logic       transmit_ready,
  output logic       ack_a,
  output logic       ack_b,
  output logic       tx_ctrl,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       src,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_tx_byte;
  logic       r_src, r_last_b;
  logic       w_grant, w_win_b, w_expire;
  assign w_grant = transmit_ready & (req_a | req_b);
  // on a tie the requester not served last wins
  assign w_win_b = req_b & (~req_a | ~r_last_b);
`ifdef TXARB_TIMEOUT_EN
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] r_wdog;
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) r_wdog <= '0;
    else if (r_state == START) r_wdog <= '0;
    else if (r_state != IDLE) r_wdog <= r_wdog + 1'b1;
  // a completing WAIT_DONE cycle wins over expiry
  assign w_expire = (r_state == WAIT_BUSY || (r_state == WAIT_DONE && !transmit_ready))
                    && r_wdog == W'(TIMEOUT_CYCLES - 1);
`else
  assign w_expire = 1'b0;
`endif
  always_comb begin
    w_next  = r_state;
    ack_a   = 1'b0;
    ack_b   = 1'b0;
    tx_ctrl = 1'b0;
    busy    = r_state != IDLE;
    err     = w_expire;
    case (r_state)
      IDLE:      w_next = w_grant ? START : IDLE;
      START: begin
        w_next  = WAIT_BUSY;
        tx_ctrl = 1'b1;
        ack_a   = ~r_src;
        ack_b   = r_src;
      end
      WAIT_BUSY: w_next = w_expire ? IDLE : (transmit_ready ? WAIT_BUSY : WAIT_DONE);
      WAIT_DONE: w_next = (w_expire || transmit_ready) ? IDLE : WAIT_DONE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      r_state   <= IDLE;
      r_tx_byte <= 8'h00;
      r_src     <= 1'b0;
      r_last_b  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_grant) begin
        r_tx_byte <= w_win_b ? data_b : data_a;
        r_src     <= w_win_b;
        r_last_b  <= w_win_b;
      end
    end
  assign tx_byte = r_tx_byte;
  assign src     = r_src;
endmodule
